// File: rtl/ahb_master_req_ctrl_pkg.sv
// Shared types and slave address map for the AHB master request controller.
package ahb_master_req_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } mreq_state_e;

  localparam int unsigned MAP_NUM   = 3;
  localparam int unsigned MAP_AW    = 32;
  localparam int unsigned MAP_IDX_W = 2;

  // Each slave owns a 256 MB window; addresses 0x3000_0000 and above decode to nobody.
  localparam logic [MAP_AW-1:0] SLAVE_BASE [MAP_NUM] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [MAP_AW-1:0] SLAVE_MASK [MAP_NUM] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  function automatic logic addr_hit(input logic [MAP_AW-1:0] addr, input logic [MAP_IDX_W-1:0] idx);
    return (addr & SLAVE_MASK[idx]) == SLAVE_BASE[idx];
  endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_decode.sv
// Combinational command-address decode to a one-hot slave select; lowest matching window wins.
module ahb_slave_addr_decode
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int unsigned SLAVE_NUM = 3,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic [ADDR_W-1:0]    addr_i,
  output logic [SLAVE_NUM-1:0] sel_c_o,
  output logic                 hit_c_o
);

  logic [SLAVE_NUM-1:0] match_c;

  for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_match
    assign match_c[i] = addr_hit(MAP_AW'(addr_i), MAP_IDX_W'(i));
  end

  // Isolate the lowest set bit so overlapping windows still give a one-hot select.
  assign sel_c_o = match_c & (~match_c + SLAVE_NUM'(1));
  assign hit_c_o = |match_c;

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// Per-master AHB burst request controller: decode, request, beat count, hlast.
// Optional grant-wait abort is compiled in with `define MREQ_TIMEOUT_EN.
module ahb_master_req_ctrl
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int unsigned SLAVE_NUM   = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic [SLAVE_NUM-1:0] hreq,
  output logic [SLAVE_NUM-1:0] hlast,
  input  logic [SLAVE_NUM-1:0] hgrant,
  input  logic                 hwait,
  output logic                 beat_done,
  output logic                 burst_done,
  output logic                 cmd_err
);

  mreq_state_e          state_q, state_d;
  logic [SLAVE_NUM-1:0] sel_q, sel_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [SLAVE_NUM-1:0] hreq_q, hreq_d;
  logic [SLAVE_NUM-1:0] hlast_q, hlast_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 beat_done_q, beat_done_d;
  logic                 burst_done_q, burst_done_d;
  logic                 cmd_err_q, cmd_err_d;

  logic [SLAVE_NUM-1:0] dec_sel_c;
  logic                 dec_hit_c;
  logic                 grant_c;
  logic                 busy_c;

`ifdef MREQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  // hwait is already folded into hgrant by the arbiter.
  logic unused_c;
  assign unused_c = ^{hwait, 32'(TIMEOUT_CYC)};

  ahb_slave_addr_decode #(
    .SLAVE_NUM (SLAVE_NUM),
    .ADDR_W    (ADDR_W)
  ) u_decode (
    .addr_i  (cmd_addr),
    .sel_c_o (dec_sel_c),
    .hit_c_o (dec_hit_c)
  );

  assign grant_c = |(hgrant & sel_q);

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    beat_done_d  = 1'b0;
    burst_done_d = 1'b0;
    cmd_err_d    = 1'b0;
`ifdef MREQ_TIMEOUT_EN
    wait_d       = wait_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (dec_hit_c) begin
            sel_d   = dec_sel_c;
            len_d   = cmd_len;
            cnt_d   = '0;
            state_d = REQ;
`ifdef MREQ_TIMEOUT_EN
            wait_d  = '0;
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      REQ, XFER: begin
        if (grant_c) begin
          beat_done_d = 1'b1;
`ifdef MREQ_TIMEOUT_EN
          wait_d      = '0;
`endif
          if (cnt_q == len_q) begin
            state_d      = IDLE;
            burst_done_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            state_d = XFER;
          end
        end
`ifdef MREQ_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = IDLE;
          cmd_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it at the edge.
    busy_c      = (state_d != IDLE);
    hreq_d      = busy_c ? sel_d : '0;
    hlast_d     = (busy_c && (cnt_d == len_d)) ? sel_d : '0;
    cmd_ready_d = !busy_c;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      hreq_q       <= '0;
      hlast_q      <= '0;
      cmd_ready_q  <= 1'b0;
      beat_done_q  <= 1'b0;
      burst_done_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      hreq_q       <= hreq_d;
      hlast_q      <= hlast_d;
      cmd_ready_q  <= cmd_ready_d;
      beat_done_q  <= beat_done_d;
      burst_done_q <= burst_done_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

`ifdef MREQ_TIMEOUT_EN
  always_ff @(posedge hclk) begin
    if (hreset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign cmd_ready  = cmd_ready_q;
  assign hreq       = hreq_q;
  assign hlast      = hlast_q;
  assign beat_done  = beat_done_q;
  assign burst_done = burst_done_q;
  assign cmd_err    = cmd_err_q;

endmodule
